fp_sqrt_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined fp_sqrt instance among NUM_REQ requesters.
- Accepts requests over per-requester valid/ready and issues at most one operand per cycle to the datapath.
- Tracks in-flight operations with a tag pipeline matched to the fp_sqrt latency, and returns results on a single tagged output channel with backpressure.
- Sits between the FPU issue logic and the fp_sqrt datapath; the fp_sqrt instance is external and driven through the sqrt_* ports.

---
 rtl/fp_sqrt_sched_pkg.sv | 25 ++
 rtl/fp_sqrt_sched_if.sv | 42 ++++
 rtl/fp_sqrt_sched_rr_arbiter.sv | 40 ++++
 rtl/fp_sqrt_sched.sv | 104 ++++++++++
 tb/tb_fp_sqrt_sched.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_sqrt_sched_pkg.sv
// rtl/fp_sqrt_sched_pkg.sv - shared types and constants for the fp_sqrt issue scheduler
package fp_sqrt_sched_pkg;

    localparam int SQRT_STATUS_W = 8;
    localparam int ROUND_W       = 3;
    localparam int TAG_ID_W      = 3;

    typedef enum logic [ROUND_W-1:0] {
        RND_NE   = 3'd0,
        RND_ZERO = 3'd1,
        RND_PINF = 3'd2,
        RND_NINF = 3'd3,
        RND_NUP  = 3'd4,
        RND_AWAY = 3'd5,
        RND_RSV6 = 3'd6,
        RND_RSV7 = 3'd7
    } round_t;

    // id is sized for the largest supported requester count (8)
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } sched_tag_t;

endpackage

// File: rtl/fp_sqrt_sched_if.sv
// rtl/fp_sqrt_sched_if.sv - requester, datapath and result channels of the fp_sqrt scheduler
interface fp_sqrt_sched_if
    import fp_sqrt_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int sig_width = 23,
    parameter int ex_width  = 8
) ();
    localparam int W     = sig_width + ex_width + 1;
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*W-1:0]       req_a;
    logic [NUM_REQ*ROUND_W-1:0] req_round;
    logic [NUM_REQ-1:0]         req_ready;

    logic [W-1:0]               sqrt_a;
    round_t                     sqrt_round;
    logic                       sqrt_enable;
    logic                       sqrt_resetn;
    logic [W-1:0]               sqrt_z;
    logic [SQRT_STATUS_W-1:0]   sqrt_status;

    logic                       res_valid;
    logic                       res_ready;
    logic [IDX_W-1:0]           res_id;
    logic [W-1:0]               res_z;
    logic [SQRT_STATUS_W-1:0]   res_status;

    modport master (
        input  req_valid, req_a, req_round, sqrt_z, sqrt_status, res_ready,
        output req_ready, sqrt_a, sqrt_round, sqrt_enable, sqrt_resetn,
               res_valid, res_id, res_z, res_status
    );

    modport slave (
        output req_valid, req_a, req_round, sqrt_z, sqrt_status, res_ready,
        input  req_ready, sqrt_a, sqrt_round, sqrt_enable, sqrt_resetn,
               res_valid, res_id, res_z, res_status
    );

endinterface

// File: rtl/fp_sqrt_sched_rr_arbiter.sv
// rtl/fp_sqrt_sched_rr_arbiter.sv - rotating-priority arbiter; pointer moves past the winner on advance
module fp_sqrt_sched_rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;

    // scan downward so the lowest offset from ptr is the last writer and wins
    always_comb begin
        int j;
        j           = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (req[j[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = j[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fp_sqrt_sched.sv
// rtl/fp_sqrt_sched.sv - round-robin issue of NUM_REQ requesters onto one pipelined fp_sqrt
// FP_SQRT_SCHED_STATS_EN adds saturating stat_issued / stat_stall counters.
module fp_sqrt_sched
    import fp_sqrt_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int sig_width   = 23,
    parameter int ex_width    = 8,
    parameter int pipe_stages = 0
) (
    input  logic             clk,
    input  logic             reset,
    fp_sqrt_sched_if.master  bus
`ifdef FP_SQRT_SCHED_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_stall
`endif
);

    localparam int W     = sig_width + ex_width + 1;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int LAT   = pipe_stages;

    logic             arb_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             issue_valid;
    logic             accept;
    logic             sqrt_enable;
    logic             res_valid;
    logic [IDX_W-1:0] last_id;

    fp_sqrt_sched_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (bus.req_valid),
        .advance     (accept),
        .grant_valid (arb_valid),
        .grant_idx   (grant_idx)
    );

    assign issue_valid = arb_valid & ~reset;
    assign sqrt_enable = ~res_valid | bus.res_ready;
    assign accept      = issue_valid & sqrt_enable;

    generate
        if (LAT == 0) begin : g_comb
            // the issue slot is the output slot: result is the live datapath output
            assign res_valid = issue_valid;
            assign last_id   = grant_idx;
        end else begin : g_pipe
            sched_tag_t tags [LAT];
            sched_tag_t new_tag;

            assign new_tag.valid = issue_valid;
            assign new_tag.id    = TAG_ID_W'(grant_idx);

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < LAT; k++) tags[k] <= '0;
                end else if (sqrt_enable) begin
                    tags[0] <= new_tag;
                    for (int k = LAT - 1; k > 0; k--) tags[k] <= tags[k-1];
                end
            end

            assign res_valid = tags[LAT-1].valid;
            assign last_id   = tags[LAT-1].id[IDX_W-1:0];
        end
    endgenerate

    always_comb begin
        bus.sqrt_a     = '0;
        bus.sqrt_round = RND_NE;
        bus.req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (issue_valid && grant_idx == IDX_W'(i)) begin
                bus.sqrt_a       = bus.req_a[i*W +: W];
                bus.sqrt_round   = round_t'(bus.req_round[i*ROUND_W +: ROUND_W]);
                bus.req_ready[i] = sqrt_enable;
            end
        end
    end

    assign bus.sqrt_enable = sqrt_enable;
    assign bus.sqrt_resetn = ~reset;
    assign bus.res_valid   = res_valid;
    assign bus.res_id      = last_id;
    assign bus.res_z       = bus.sqrt_z;
    assign bus.res_status  = bus.sqrt_status;

`ifdef FP_SQRT_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (accept && stat_issued != '1) stat_issued <= stat_issued + 32'd1;
            if (!sqrt_enable && res_valid && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_sqrt_sched.sv
// tb/tb_fp_sqrt_sched.sv - directed bench for fp_sqrt_sched with 3-stage and combinational datapath models
module tb_fp_sqrt_sched;
    import fp_sqrt_sched_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp_sqrt_sched_if #(.NUM_REQ(4), .sig_width(23), .ex_width(8)) if3 ();
    fp_sqrt_sched_if #(.NUM_REQ(4), .sig_width(23), .ex_width(8)) if0 ();

`ifdef FP_SQRT_SCHED_STATS_EN
    logic [31:0] st3_issued, st3_stall, st0_issued, st0_stall;
`endif

    fp_sqrt_sched #(.NUM_REQ(4), .sig_width(23), .ex_width(8), .pipe_stages(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
`ifdef FP_SQRT_SCHED_STATS_EN
        , .stat_issued (st3_issued), .stat_stall (st3_stall)
`endif
    );

    fp_sqrt_sched #(.NUM_REQ(4), .sig_width(23), .ex_width(8), .pipe_stages(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
`ifdef FP_SQRT_SCHED_STATS_EN
        , .stat_issued (st0_issued), .stat_stall (st0_stall)
`endif
    );

    // small square-root table standing in for the external datapath: {status, z}
    function automatic logic [39:0] sqrt_fn(input logic [31:0] a);
        case (a)
            32'h3F800000: return {8'h00, 32'h3F800000};
            32'h40800000: return {8'h00, 32'h40000000};
            32'h41100000: return {8'h00, 32'h40400000};
            32'h41800000: return {8'h00, 32'h40800000};
            32'hBF800000: return {8'h04, 32'h7FC00000};
            default:      return {8'h01, 32'h00000000};
        endcase
    endfunction

    logic [31:0] m3_z [3];
    logic [7:0]  m3_s [3];

    always @(posedge clk) begin
        if (!if3.sqrt_resetn) begin
            for (int k = 0; k < 3; k++) begin
                m3_z[k] <= '0;
                m3_s[k] <= '0;
            end
        end else if (if3.sqrt_enable) begin
            {m3_s[0], m3_z[0]} <= sqrt_fn(if3.sqrt_a);
            m3_z[1] <= m3_z[0];
            m3_s[1] <= m3_s[0];
            m3_z[2] <= m3_z[1];
            m3_s[2] <= m3_s[1];
        end
    end

    assign if3.sqrt_z      = m3_z[2];
    assign if3.sqrt_status = m3_s[2];
    assign {if0.sqrt_status, if0.sqrt_z} = sqrt_fn(if0.sqrt_a);

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        if3.req_valid = '0; if3.req_a = '0; if3.req_round = '0; if3.res_ready = 1'b1;
        if0.req_valid = '0; if0.req_a = '0; if0.req_round = '0; if0.res_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        if3.req_valid = 4'hF;
        if0.req_valid = 4'hF;
        cyc();
        #1;
        checks++; if (if3.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready3 got %b exp 0000", if3.req_ready); end
        checks++; if (if3.res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid3 got %b exp 0", if3.res_valid); end
        checks++; if (if0.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready0 got %b exp 0000", if0.req_ready); end
        checks++; if (if0.res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid0 got %b exp 0", if0.res_valid); end
        checks++; if (if3.sqrt_resetn !== 1'b0) begin errors++; $display("FAIL rst_sqrt_resetn got %b exp 0", if3.sqrt_resetn); end
        cyc();
        reset = 1'b0;
        if3.req_valid = '0;
        if0.req_valid = '0;
        #1;
        checks++; if (if3.res_valid !== 1'b0) begin errors++; $display("FAIL rst_after_valid3 got %b exp 0", if3.res_valid); end
        cyc();
    endtask

    task automatic test_basic_issue();
        logic exp_v;
        do_reset();
        if3.req_a[2*32 +: 32] = 32'h40800000;
        if3.req_valid = 4'b0100;
        #1;
        checks++; if (if3.req_ready !== 4'b0100) begin errors++; $display("FAIL basic_ready got %b exp 0100", if3.req_ready); end
        checks++; if (if3.sqrt_a !== 32'h40800000) begin errors++; $display("FAIL basic_sqrt_a got %h exp 40800000", if3.sqrt_a); end
        cyc();
        if3.req_valid = '0;
        for (int t = 1; t <= 4; t++) begin
            #1;
            exp_v = (t == 3);
            checks++; if (if3.res_valid !== exp_v) begin errors++; $display("FAIL basic_valid t=%0d got %b exp %b", t, if3.res_valid, exp_v); end
            if (t == 3) begin
                checks++; if (if3.res_z !== 32'h40000000) begin errors++; $display("FAIL basic_z got %h exp 40000000", if3.res_z); end
                checks++; if (if3.res_id !== 2'd2) begin errors++; $display("FAIL basic_id got %0d exp 2", if3.res_id); end
            end
            cyc();
        end
`ifdef FP_SQRT_SCHED_STATS_EN
        checks++; if (st3_issued !== 32'd1) begin errors++; $display("FAIL stat_issued got %0d exp 1", st3_issued); end
`endif
    endtask

    task automatic test_fairness();
        logic [31:0] exp_z [4];
        logic [3:0]  exp_rdy;
        exp_z[0] = 32'h3F800000; exp_z[1] = 32'h40000000;
        exp_z[2] = 32'h40400000; exp_z[3] = 32'h40800000;
        do_reset();
        if3.req_a = {32'h41800000, 32'h41100000, 32'h40800000, 32'h3F800000};
        if3.req_valid = 4'hF;
        for (int t = 0; t < 9; t++) begin
            #1;
            if (t < 6) begin
                exp_rdy = 4'b0001 << (t % 4);
                checks++; if (if3.req_ready !== exp_rdy) begin errors++; $display("FAIL fair_ready t=%0d got %b exp %b", t, if3.req_ready, exp_rdy); end
            end
            if (t >= 3) begin
                checks++; if (if3.res_valid !== 1'b1) begin errors++; $display("FAIL fair_valid t=%0d got %b exp 1", t, if3.res_valid); end
                checks++; if (int'(if3.res_id) != (t - 3) % 4) begin errors++; $display("FAIL fair_id t=%0d got %0d exp %0d", t, if3.res_id, (t - 3) % 4); end
                checks++; if (if3.res_z !== exp_z[(t - 3) % 4]) begin errors++; $display("FAIL fair_z t=%0d got %h exp %h", t, if3.res_z, exp_z[(t - 3) % 4]); end
            end
            cyc();
        end
        if3.req_valid = '0;
        repeat (4) cyc();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_z [4];
        logic [1:0]  exp_id [4];
        int          k;
        exp_z[0] = 32'h40400000; exp_id[0] = 2'd0;
        exp_z[1] = 32'h40800000; exp_id[1] = 2'd1;
        exp_z[2] = 32'h40000000; exp_id[2] = 2'd2;
        exp_z[3] = 32'h3F800000; exp_id[3] = 2'd3;
        do_reset();
        if3.req_a = {32'h3F800000, 32'h40800000, 32'h41800000, 32'h41100000};
        if3.res_ready = 1'b0;
        if3.req_valid = 4'b0111;
        for (int t = 0; t < 13; t++) begin
            if (t == 3) if3.req_valid = 4'b1000;
            if (t == 8) if3.res_ready = 1'b1;
            if (t == 9) if3.req_valid = '0;
            #1;
            if (t >= 3 && t <= 7) begin
                checks++; if (if3.sqrt_enable !== 1'b0) begin errors++; $display("FAIL bp_enable t=%0d got %b exp 0", t, if3.sqrt_enable); end
                checks++; if (if3.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready t=%0d got %b exp 0000", t, if3.req_ready); end
            end
            if (t >= 3 && t <= 11) begin
                k = (t <= 8) ? 0 : t - 8;
                checks++; if (if3.res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid t=%0d got %b exp 1", t, if3.res_valid); end
                checks++; if (if3.res_z !== exp_z[k]) begin errors++; $display("FAIL bp_z t=%0d got %h exp %h", t, if3.res_z, exp_z[k]); end
                checks++; if (if3.res_id !== exp_id[k]) begin errors++; $display("FAIL bp_id t=%0d got %0d exp %0d", t, if3.res_id, exp_id[k]); end
            end
            if (t == 8) begin
                checks++; if (if3.req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b exp 1000", if3.req_ready); end
            end
            if (t == 12) begin
                checks++; if (if3.res_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", if3.res_valid); end
            end
            cyc();
        end
`ifdef FP_SQRT_SCHED_STATS_EN
        checks++; if (st3_stall !== 32'd5) begin errors++; $display("FAIL stat_stall got %0d exp 5", st3_stall); end
`endif
    endtask

    task automatic test_exception();
        do_reset();
        if3.req_a[1*32 +: 32] = 32'hBF800000;
        if3.req_valid = 4'b0010;
        #1;
        checks++; if (if3.req_ready !== 4'b0010) begin errors++; $display("FAIL exc_ready got %b exp 0010", if3.req_ready); end
        cyc();
        if3.req_valid = '0;
        cyc();
        cyc();
        #1;
        checks++; if (if3.res_valid !== 1'b1) begin errors++; $display("FAIL exc_valid got %b exp 1", if3.res_valid); end
        checks++; if (if3.res_status[2] !== 1'b1) begin errors++; $display("FAIL exc_nan got %b exp 1", if3.res_status[2]); end
        checks++; if (if3.res_id !== 2'd1) begin errors++; $display("FAIL exc_id got %0d exp 1", if3.res_id); end
        checks++; if (if3.res_z !== 32'h7FC00000) begin errors++; $display("FAIL exc_z got %h exp 7fc00000", if3.res_z); end
        cyc();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        if3.req_a = {32'h41800000, 32'h41100000, 32'h40800000, 32'h3F800000};
        if3.req_valid = 4'b0111;
        repeat (3) cyc();
        reset = 1'b1;
        if3.req_valid = 4'hF;
        #1;
        checks++; if (if3.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", if3.req_ready); end
        checks++; if (if3.sqrt_resetn !== 1'b0) begin errors++; $display("FAIL mid_sqrt_resetn got %b exp 0", if3.sqrt_resetn); end
        cyc();
        reset = 1'b0;
        #1;
        checks++; if (if3.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_next_grant got %b exp 0001", if3.req_ready); end
        for (int t = 4; t <= 8; t++) begin
            #1;
            if (t < 7) begin
                checks++; if (if3.res_valid !== 1'b0) begin errors++; $display("FAIL mid_dropped t=%0d got %b exp 0", t, if3.res_valid); end
            end
            if (t == 7) begin
                checks++; if (if3.res_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid got %b exp 1", if3.res_valid); end
                checks++; if (if3.res_id !== 2'd0) begin errors++; $display("FAIL mid_new_id got %0d exp 0", if3.res_id); end
                checks++; if (if3.res_z !== 32'h3F800000) begin errors++; $display("FAIL mid_new_z got %h exp 3f800000", if3.res_z); end
            end
            if (t == 8) begin
                checks++; if (if3.res_valid !== 1'b0) begin errors++; $display("FAIL mid_tail got %b exp 0", if3.res_valid); end
            end
            cyc();
            if (t == 4) if3.req_valid = '0;
        end
    endtask

    task automatic test_pipe0();
        do_reset();
        if0.req_a = {32'h41800000, 32'h3F800000, 32'h41100000, 32'h40800000};
        if0.req_valid = 4'b0001;
        #1;
        checks++; if (if0.res_valid !== 1'b1) begin errors++; $display("FAIL p0_valid got %b exp 1", if0.res_valid); end
        checks++; if (if0.res_z !== 32'h40000000) begin errors++; $display("FAIL p0_z got %h exp 40000000", if0.res_z); end
        checks++; if (if0.res_id !== 2'd0) begin errors++; $display("FAIL p0_id got %0d exp 0", if0.res_id); end
        checks++; if (if0.req_ready !== 4'b0001) begin errors++; $display("FAIL p0_ready got %b exp 0001", if0.req_ready); end
        cyc();
        if0.req_valid = 4'b0010;
        if0.res_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            #1;
            checks++; if (if0.req_ready !== 4'b0000) begin errors++; $display("FAIL p0_stall_ready t=%0d got %b exp 0000", t, if0.req_ready); end
            checks++; if (if0.sqrt_enable !== 1'b0) begin errors++; $display("FAIL p0_stall_en t=%0d got %b exp 0", t, if0.sqrt_enable); end
            checks++; if (if0.res_valid !== 1'b1) begin errors++; $display("FAIL p0_stall_valid t=%0d got %b exp 1", t, if0.res_valid); end
            checks++; if (if0.res_z !== 32'h40400000) begin errors++; $display("FAIL p0_stall_z t=%0d got %h exp 40400000", t, if0.res_z); end
            cyc();
        end
        if0.req_valid = 4'b0011;
        if0.res_ready = 1'b1;
        #1;
        checks++; if (if0.req_ready !== 4'b0010) begin errors++; $display("FAIL p0_kept_prio got %b exp 0010", if0.req_ready); end
        checks++; if (if0.res_id !== 2'd1) begin errors++; $display("FAIL p0_kept_id got %0d exp 1", if0.res_id); end
        cyc();
        #1;
        checks++; if (if0.req_ready !== 4'b0001) begin errors++; $display("FAIL p0_wrap got %b exp 0001", if0.req_ready); end
        cyc();
        if0.req_valid = '0;
        #1;
        checks++; if (if0.res_valid !== 1'b0) begin errors++; $display("FAIL p0_idle got %b exp 0", if0.res_valid); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_fairness();
        test_backpressure();
        test_exception();
        test_reset_midflight();
        test_pipe0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
